mem_access_unit: RTL and testbench

Multicycle load/store controller sitting directly downstream of the memory-address select mux. It consumes the 32-bit byte address chosen by that mux (PC, ALU result, extended immediate, ALU-out register, exception-vector bytes 253/254/255, or jump target) and performs word, halfword or byte accesses against a word-wide, single-port, synchronous-read RAM. Sub-word stores are done as read-modify-write. The control unit sees a simple start/busy/done handshake.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 115 +++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store path: access sizes, controller states,
// exception-vector byte addresses and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Exception-vector byte addresses, also selectable by the address mux.
  localparam logic [31:0] EXC_VEC_0 = 32'd253;
  localparam logic [31:0] EXC_VEC_1 = 32'd254;
  localparam logic [31:0] EXC_VEC_2 = 32'd255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } mau_state_t;

  // size 2'b11 is an illegal encoding and is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_WORD: is_misaligned = (offset != 2'b00);
      SZ_HALF: is_misaligned = offset[0];
      SZ_BYTE: is_misaligned = 1'b0;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends a load lane, and inserts
// a store lane into the word read back for read-modify-write.
import mem_pkg::*;

module mem_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (size)
      SZ_HALF: load_data = {{16{sext & half_lane[15]}}, half_lane};
      SZ_BYTE: load_data = {{24{sext & byte_lane[7]}}, byte_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_HALF: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store controller against a single-port synchronous-read RAM;
// sub-word stores are read-modify-write.
import mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output mau_state_t        state
);

  // Handshake: a request is accepted on a rising edge where state is IDLE and
  // start is high; busy stays high until the single-cycle done pulse ends, and
  // start is ignored (not queued) whenever busy is high.

  mau_state_t        state_q, state_d;
  logic              we_q, sext_q, err_q;
  logic [1:0]        size_q, off_q;
  logic [31:0]       wdata_q, rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       load_data, merged;
  logic              accept, misaligned;

  assign accept     = (state_q == ST_IDLE) && start;
  assign misaligned = is_misaligned(size, addr[1:0]);

  mem_lane_align u_align (
    .size      (size_q),
    .offset    (off_q),
    .sext      (sext_q),
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (misaligned)                 state_d = ST_DONE;
          else if (we && size == SZ_WORD) state_d = ST_WRITE;
          else                            state_d = ST_READ;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = we_q ? ST_WRITE : ST_DONE;
      ST_WRITE:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= SZ_WORD;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        off_q   <= addr[1:0];
        wdata_q <= wdata;
        err_q   <= misaligned;
        // An erroring request never touches the RAM, so the bus stays put.
        if (!misaligned) begin
          mem_addr_q <= addr[ADDR_W+1:2];
          if (we && size == SZ_WORD) mem_wdata_q <= wdata;
        end
      end
      if (state_q == ST_CAPTURE) begin
        if (we_q) mem_wdata_q <= merged;
        else      rdata_q     <= load_data;
      end
    end
  end

  assign state     = state_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign mem_rd    = (state_q == ST_READ);
  assign mem_wr    = (state_q == ST_WRITE);
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand-written
// busy-start and reset-during-RMW sequences, against a behavioural RAM.
import mem_pkg::*;

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ram_init = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, mem_rd, mem_wr;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  mau_state_t  state;

  logic [31:0] ram [0:255];
  logic [31:0] ram_q = '0;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .we        (we),
    .size      (size),
    .sext      (sext),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state     (state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[4]  <= 32'hDEADBEEF;
      ram[8]  <= 32'h11223344;
      ram[16] <= 32'h01020304;
      ram[63] <= 32'h00008000;
      ram_q   <= 32'h0;
    end else begin
      if (mem_rd) ram_q <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wword;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int done_cnt, lat, rd_cnt, wr_cnt;
    logic err_seen;
    logic [31:0] rdata_seen, exp_waddr;

    //            we    size     sext  addr   wdata          rdata          err  lat rd wr wword
    vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0};
    vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'd253, 32'h0,       32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h0};
    vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'd253, 32'h0,       32'h00000080, 1'b0, 3, 1, 0, 32'h0};
    vecs[3]  = '{1'b1, SZ_HALF, 1'b0, 32'h22, 32'h5555ABCD, 32'h00000080, 1'b0, 4, 1, 1, 32'hABCD3344};
    vecs[4]  = '{1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0,        32'h00000080, 1'b1, 1, 0, 0, 32'h0};
    vecs[5]  = '{1'b1, SZ_HALF, 1'b0, 32'h21, 32'h1234,     32'h00000080, 1'b1, 1, 0, 0, 32'h0};
    vecs[6]  = '{1'b1, SZ_WORD, 1'b0, 32'h30, 32'hCAFEF00D, 32'h00000080, 1'b0, 2, 0, 1, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0,        32'hFFFFABCD, 1'b0, 3, 1, 0, 32'h0};
    vecs[8]  = '{1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0,        32'h00003344, 1'b0, 3, 1, 0, 32'h0};
    vecs[9]  = '{1'b0, 2'b11,   1'b0, 32'h10, 32'h0,        32'h00003344, 1'b1, 1, 0, 0, 32'h0};
    vecs[10] = '{1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hFFFFFF5A, 32'h00003344, 1'b0, 4, 1, 1, 32'h5AADBEEF};
    vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h0000005A, 1'b0, 3, 1, 0, 32'h0};

    // reset block
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_state", {29'b0, state}, {29'b0, ST_IDLE});
    reset = 1'b0;
    ram_init = 1'b0;

    // vector table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we = vecs[i].we; size = vecs[i].size; sext = vecs[i].sext;
      addr = vecs[i].addr; wdata = vecs[i].wdata; start = 1'b1;
      exp_waddr = {24'b0, vecs[i].addr[9:2]};
      @(posedge clk);
      #1;
      // scrambled inputs after acceptance must not matter
      start = 1'b0; we = ~we; size = 2'b11; sext = ~sext;
      addr = 32'hFFFF_FFFF; wdata = 32'h9999_9999;
      done_cnt = 0; lat = 0; rd_cnt = 0; wr_cnt = 0;
      err_seen = 1'b0; rdata_seen = '0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) check($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h1);
        if (mem_rd) begin
          rd_cnt++;
          check($sformatf("v%0d_rd_addr", i), {24'b0, mem_addr}, exp_waddr);
        end
        if (mem_wr) begin
          wr_cnt++;
          check($sformatf("v%0d_wr_addr", i), {24'b0, mem_addr}, exp_waddr);
          check($sformatf("v%0d_wr_word", i), mem_wdata, vecs[i].exp_wword);
        end
        if (done) begin
          done_cnt++;
          if (lat == 0) lat = k;
          err_seen = err;
          rdata_seen = rdata;
        end
      end
      check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err", i), {31'b0, err_seen}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), rdata_seen, vecs[i].exp_rdata);
      check($sformatf("v%0d_rd_cnt", i), rd_cnt, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_cnt", i), wr_cnt, vecs[i].exp_wr);
    end
    check("ram_word_0x20", ram[8], 32'hABCD3344);
    check("ram_word_0x30", ram[12], 32'hCAFEF00D);

    // start held into the busy cycle after a store word must not start a second access
    @(negedge clk);
    we = 1'b1; size = SZ_WORD; sext = 1'b0; addr = 32'h34; wdata = 32'h12345678; start = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; addr = 32'h10;
    done_cnt = 0; lat = 0; rd_cnt = 0; wr_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
      if (mem_wr) begin
        wr_cnt++;
        check("busy_wr_word", mem_wdata, 32'h12345678);
      end
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
      if (k == 1) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check("busy_done_cnt", done_cnt, 1);
    check("busy_latency", lat, 2);
    check("busy_rd_cnt", rd_cnt, 0);
    check("busy_wr_cnt", wr_cnt, 1);
    check("ram_word_0x34", ram[13], 32'h12345678);

    // reset while a byte read-modify-write sits in CAPTURE
    @(negedge clk);
    we = 1'b1; size = SZ_BYTE; sext = 1'b0; addr = 32'h41; wdata = 32'h77; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmw_in_capture", {29'b0, state}, {29'b0, ST_CAPTURE});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_err", {31'b0, err}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_mem_rd", {31'b0, mem_rd}, 32'h0);
    check("abort_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("abort_mem_addr", {24'b0, mem_addr}, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    wr_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
    end
    check("abort_wr_cnt", wr_cnt, 0);
    check("abort_ram_word", ram[16], 32'h01020304);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
